// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
//
// Program counter with a built-in return-address stack (RAS). Each rising
// edge of clk applies at most one command, chosen by a fixed priority:
// illegal call+ret, call, ret, load, inc, and finally hold.
//
//   call : push out+STEP onto the stack and jump to `in`.
//   ret  : pop the top of the stack into `out`.
//   load : jump to `in`.
//   inc  : out <= out + STEP.
//
// A call on a full stack or a ret on an empty stack is rejected. The machine
// state holds, and a one-cycle ovf or unf pulse is raised. Any fault (ovf, unf
// or call+ret together) also sets the sticky err flag. Only reset clears err.
//
// Parameters
//   WIDTH        : width of in, out and each stack entry
//   DEPTH        : number of stack entries (>= 2)
//   STEP         : increment added by inc and used for the pushed return
//                  address. The sum wraps modulo 2^WIDTH.
//   RESET_VECTOR : value of out while reset is asserted
//
// Ports
//   clk      in   system clock (rising edge)
//   reset_n  in   asynchronous active-low reset
//   in       in   [WIDTH]   jump / call target
//   load     in   jump command
//   inc      in   advance command
//   call     in   subroutine call command
//   ret      in   subroutine return command
//   out      out  [WIDTH]   current program counter (registered)
//   count    out  [$clog2(DEPTH+1)] number of valid stack entries
//   ovf      out  one-cycle pulse: call rejected, stack full
//   unf      out  one-cycle pulse: ret rejected, stack empty
//   err      out  sticky fault flag
// -----------------------------------------------------------------------------
module pc_ras #(
    parameter int               WIDTH        = 16,
    parameter int               DEPTH        = 8,
    parameter int               STEP         = 1,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       unf,
    output logic                       err
);

    // CW holds the values 0..DEPTH. IW addresses entries 0..DEPTH-1.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]    ONE_C   = CW'(1);
    localparam logic [WIDTH-1:0] STEP_C  = WIDTH'(STEP);

    // Stack storage. Reset does not clear these entries. Entries at or above
    // count_q can never be observed, so stale contents are harmless.
    logic [WIDTH-1:0] stackMem [DEPTH];

    logic [WIDTH-1:0] pc_q,    pc_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;
    logic             err_q,   err_d;

    logic [WIDTH-1:0] pcPlusStep;
    logic [CW-1:0]    countDec;
    logic [IW-1:0]    pushIdx;
    logic [IW-1:0]    popIdx;
    logic             stackFull;
    logic             stackEmpty;
    logic             illegalCmd;
    logic             pushEn;

    // Values derived from the current state that several commands share.
    // pcPlusStep is both the inc target and the pushed return address, so a
    // call made at the top of the address space pushes the wrapped value.
    // When a push is allowed (count < DEPTH) or a pop is allowed
    // (count > 0), the index fits in IW bits. Slicing therefore loses
    // nothing on the paths that are used.
    always_comb begin
        pcPlusStep = pc_q + STEP_C;
        countDec   = count_q - ONE_C;
        pushIdx    = count_q[IW-1:0];
        popIdx     = countDec[IW-1:0];
        stackFull  = (count_q == DEPTH_C);
        stackEmpty = (count_q == '0);
        illegalCmd = call && ret;
    end

    // Next-state selection in priority order. call and ret together are
    // illegal: they only set err, and they block load and inc. A rejected
    // call or ret also leaves the PC alone instead of falling through to a
    // lower-priority command. ovf and unf default low, so each one lasts a
    // single cycle after the edge that raised it.
    always_comb begin
        pc_d    = pc_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        err_d   = err_q;
        pushEn  = 1'b0;

        if (illegalCmd) begin
            err_d = 1'b1;
        end else if (call) begin
            if (!stackFull) begin
                pushEn  = 1'b1;
                count_d = count_q + ONE_C;
                pc_d    = in;
            end else begin
                ovf_d = 1'b1;
                err_d = 1'b1;
            end
        end else if (ret) begin
            if (!stackEmpty) begin
                pc_d    = stackMem[popIdx];
                count_d = countDec;
            end else begin
                unf_d = 1'b1;
                err_d = 1'b1;
            end
        end else if (load) begin
            pc_d = in;
        end else if (inc) begin
            pc_d = pcPlusStep;
        end
    end

    // Architectural state. While reset_n is low the asynchronous clear holds
    // every control register at its reset value, whatever the inputs do.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_VECTOR;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            err_q   <= err_d;
        end
    end

    // Stack write port. It has no reset because the contents only matter
    // below count_q. A push while reset is low can only write a slot that
    // count_q (held at zero) already marks as invalid. A ret on the next
    // edge reads the entry written by a call on the edge before, which is
    // what allows back-to-back call/ret at full rate.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            stackMem[pushIdx] <= pcPlusStep;
        end
    end

    assign out   = pc_q;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign unf   = unf_q;
    assign err   = err_q;

endmodule

// File: doc/pc_ras.md
# pc_ras

Parametrised program counter with an integrated return-address stack (RAS). It extends the Hack CPU program counter's load/increment behaviour with configurable width and step, plus hardware call/return. The CPU drives it once per instruction cycle; `out` addresses instruction ROM.

## Interface

Parameters:
- `WIDTH`, 16: bit width of `in`, `out` and each stack entry.
- `DEPTH`, 8: number of stack entries; ≥ 2.
- `STEP`, 1: increment amount, added modulo 2^WIDTH.
- `RESET_VECTOR`, 0: value of `out` after reset.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in`  in  WIDTH  jump/call target.
- `load`  in  1  jump: `out <= in`.
- `inc`  in  1  advance: `out <= out + STEP`.
- `call`  in  1  push `out + STEP`, then `out <= in`.
- `ret`  in  1  pop top of stack into `out`.
- `out`  out  WIDTH  current program counter (registered).
- `count`  out  $clog2(DEPTH+1)  number of valid stack entries.
- `ovf`  out  1  one-cycle pulse: `call` rejected because the stack is full.
- `unf`  out  1  one-cycle pulse: `ret` rejected because the stack is empty.
- `err`  out  1  sticky: set by any `ovf`, `unf` or illegal command; cleared only by reset.

## Operation

- Per-edge priority, highest first:
  1. `call && ret`: illegal. `out` and stack hold; `err` sets; `ovf`/`unf` stay 0.
  2. `call`:
     - If `count < DEPTH`: write `out + STEP` to entry[`count`], increment `count`, set `out <= in`.
     - If full: `out` and stack hold; pulse `ovf`.
  3. `ret`:
     - If `count > 0`: set `out <= entry[count-1]`, decrement `count`.
     - If empty: `out` holds; pulse `unf`.
  4. `load`: `out <= in`.
  5. `inc`: `out <= out + STEP`.
  6. Otherwise: hold.
- `load` and `inc` are ignored whenever `call` or `ret` is asserted. `inc` is ignored whenever `load` is asserted.
- Arithmetic: all `+ STEP` sums truncate to WIDTH bits (wrap-around). Example: 0xFFFF + 1 = 0x0000.
- Stack: LIFO. Entry storage is not cleared by reset. Entries at index ≥ `count` are don't-care and never observable.
- `count` ranges 0..DEPTH and never wraps.
- Pulse rules: `ovf` and `unf` are high for exactly the cycle after the offending edge. `err` ORs in every fault.

## Timing

- All outputs are registered. No combinational path from any input to any output.
- Latency: a command sampled at edge N is visible on `out`/`count` immediately after edge N.
- Back-to-back `call`/`ret` on consecutive cycles is supported at full rate. A `ret` directly after a `call` returns the address pushed one cycle earlier.
- Reset (`reset_n` low), applied at any time including mid-call/ret:
  - immediate, clock-independent: `out = RESET_VECTOR`, `count = 0`, `ovf = unf = err = 0`.
  - Remains in force while low.
  - First command is honoured at the first rising edge after `reset_n` rises.
- Inputs are sampled only at rising edges. Glitches between edges are irrelevant.

## Test plan

Run with WIDTH=16, DEPTH=4, STEP=1, RESET_VECTOR=0.

1. **Reset, load, inc:** release reset → `out`=0. Then `load` with `in`=20 → `out`=20. Then 3 cycles of `inc` → 21, 22, 23. Then `load`+`inc` with `in`=20 → `out`=20 (load wins).
2. **Call/return nesting:**
   - At `out`=23, `call` `in`=100 → `out`=100, `count`=1.
   - `call` `in`=200 → `out`=200, `count`=2.
   - `ret` → `out`=101, `count`=1.
   - `ret` → `out`=24, `count`=0.
3. **Full and empty boundaries:**
   - 4 calls → `count`=4.
   - 5th `call` `in`=500 → `out` unchanged, `count`=4, `ovf` high 1 cycle, `err`=1.
   - 4 rets → `count`=0.
   - Extra `ret` → `out` unchanged, `unf` high 1 cycle.
4. **Wrap-around:** `load` `in`=0xFFFF, then `inc` → 0x0000. `load` 0xFFFF, then `call` `in`=5 → `out`=5; `ret` → `out`=0x0000.
5. **Simultaneous events:** `call`+`ret` at `out`=30 → `out`=30, `count` unchanged, `err`=1, no `ovf`/`unf`. `ret`+`load` with `count`=1 → pop wins.
6. **Async reset mid-operation:** with `count`=3 and `out`=300, drop `reset_n` between edges → `out`=0, `count`=0, `err`=0 before the next edge. Release, then `ret` → `unf` pulse (stack empty).
